pc_fetch_unit: RTL and testbench

//  Program-counter and instruction-fetch sequencer for the single-cycle CPU datapath.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/next_pc_calc.sv | 25 ++
 rtl/pc_fetch_unit.sv | 89 ++++++++
 tb/tb_pc_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch FSM encoding
package cpu_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_EXEC = 3'd3,
    S_HALT = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection for sequential, branch and jump
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jump_addr,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + 32'd4;

  // Reserved encoding 11 falls through to sequential; all sums wrap modulo 2^32.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PCSRC_BR:  next_pc = pc_plus4 + {imm_ext[29:0], 2'b00};
      PCSRC_JMP: next_pc = {pc_plus4[31:28], jump_addr, 2'b00};
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and instruction fetch sequencer with sticky halt
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_wre,
  input  logic [1:0]       pc_src,
  input  logic [31:0]      imm_ext,
  input  logic [25:0]      jump_addr,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  fetch_state_t state, state_nxt;
  logic [31:0]  next_pc;

  next_pc_calc u_next_pc_calc (
    .pc        (pc),
    .pc_src    (pc_src),
    .imm_ext   (imm_ext),
    .jump_addr (jump_addr),
    .next_pc   (next_pc),
    .pc_plus4  (pc_plus4)
  );

  // The fetch address is the PC itself, so it stays stable for as long as REQ is held.
  assign imem_addr = pc;

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; responses are only looked at in WAIT.
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: if (imem_rsp_valid) state_nxt = S_EXEC;
      S_EXEC: begin
        instr_valid = 1'b1;
        state_nxt   = pc_wre ? S_REQ : S_HALT;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Instruction capture, PC advance, retire count and sticky halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      instr   <= 32'h0;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      if (state == S_WAIT && imem_rsp_valid) instr <= imem_rsp_data;
      if (state == S_EXEC) begin
        if (pc_wre) begin
          pc      <= next_pc;
          retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          halted  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        pc_wre;
  logic [1:0]  pc_src;
  logic [31:0] imm_ext;
  logic [25:0] jump_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic [31:0] retired;

  pc_fetch_unit #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_wre         (pc_wre),
    .pc_src         (pc_src),
    .imm_ext        (imm_ext),
    .jump_addr      (jump_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .halted         (halted),
    .retired        (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_exec = -1;
  logic [31:0] mpc;
  logic [31:0] mret;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_restart();
    exp_q.delete();
    exp_q.push_back(32'h0);
    mpc = 32'h0;
    mret = 32'h0;
    last_exec = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    pc_wre = 1'b1;
    pc_src = 2'b00;
    imm_ext = 32'h0;
    jump_addr = 26'h0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_retired", retired, 32'h0);
    rst_n = 1'b1;
    model_restart();
  endtask

  task automatic fetch(input int rstall, input int dstall, input logic [31:0] data, input bit chk_period);
    int n;
    logic [31:0] ea;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("sb_nonempty", exp_q.size(), 32'h1);
    ea = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    chk("imem_addr", imem_addr, ea);
    for (int i = 0; i < rstall; i++) begin
      imem_req_ready = 1'b0;
      @(negedge clk);
      chk("addr_hold", {imem_addr[31:1], imem_req_valid}, {ea[31:1], 1'b1});
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("wait_no_req", {31'h0, imem_req_valid}, 32'h0);
    for (int i = 0; i < dstall; i++) begin
      @(negedge clk);
      chk("no_early_valid", {31'h0, instr_valid}, 32'h0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data = data;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    chk("instr_valid", {31'h0, instr_valid}, 32'h1);
    chk("instr", instr, data);
    chk("exec_pc", pc, ea);
    if (chk_period && last_exec >= 0) chk("period", cyc - last_exec, 32'd3);
    last_exec = cyc;
  endtask

  task automatic exec(input logic we, input logic [1:0] src, input logic [31:0] imm, input logic [25:0] ja);
    logic [31:0] p4;
    p4 = mpc + 32'd4;
    pc_wre = we;
    pc_src = src;
    imm_ext = imm;
    jump_addr = ja;
    if (we) begin
      case (src)
        2'b01:   mpc = p4 + (imm << 2);
        2'b10:   mpc = {p4[31:28], ja, 2'b00};
        default: mpc = p4;
      endcase
      mret = mret + 32'd1;
      exp_q.push_back(mpc);
    end
    @(negedge clk);
    pc_wre = 1'b1;
    pc_src = 2'b00;
    imm_ext = 32'h0;
    jump_addr = 26'h0;
    chk("instr_valid_drop", {31'h0, instr_valid}, 32'h0);
    chk("retired", retired, mret);
    chk("pc_after", pc, mpc);
    chk("halted", {31'h0, halted}, {31'h0, ~we});
  endtask

  initial begin
    do_reset();
    // Sequential fetches at 0x0, 0x4, 0x8 with no stalls; reserved pc_src acts as sequential.
    fetch(0, 0, 32'h2000_0001, 1'b1); exec(1'b1, 2'b00, 32'h0, 26'h0);
    fetch(0, 0, 32'h2000_0002, 1'b1); exec(1'b1, 2'b11, 32'h1234, 26'h3FF);
    fetch(0, 0, 32'h2000_0003, 1'b1); exec(1'b1, 2'b00, 32'h0, 26'h0);
    // Request stall then response stall.
    fetch(4, 0, 32'h2000_0004, 1'b0); exec(1'b1, 2'b00, 32'h0, 26'h0);
    fetch(0, 5, 32'h2000_0005, 1'b0); exec(1'b1, 2'b01, 32'hFFFF_FFFE, 26'h0);
    // Halt at retired=5 from pc=0x0C; pc_src must be ignored.
    fetch(0, 0, {OP_HALT, 26'h0}, 1'b1); exec(1'b0, 2'b10, 32'h0, 26'h55);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("halt_no_req", {30'h0, imem_req_valid, instr_valid}, 32'h0);
    end
    chk("halt_pc", pc, 32'h0000_000C);
    chk("halt_retired", retired, 32'd5);
    chk("halt_sticky", {31'h0, halted}, 32'h1);

    do_reset();
    // Branch to 0x4000_0000, jump to 0x4000_0040, then wrap through 0xFFFF_FFFC.
    fetch(0, 0, 32'h3000_0001, 1'b1); exec(1'b1, 2'b01, 32'h0FFF_FFFF, 26'h0);
    fetch(0, 0, 32'h3000_0002, 1'b1); exec(1'b1, 2'b10, 32'h0, 26'h10);
    fetch(0, 0, 32'h3000_0003, 1'b1); exec(1'b1, 2'b00, 32'h0, 26'h0);
    fetch(0, 0, 32'h3000_0004, 1'b1); exec(1'b1, 2'b01, 32'h2FFF_FFED, 26'h0);
    fetch(0, 0, 32'h3000_0005, 1'b1); exec(1'b1, 2'b00, 32'h0, 26'h0);

    // Reset while WAITing with a stale response held across reset and IDLE.
    fetch(0, 0, 32'h3000_0006, 1'b1); exec(1'b1, 2'b00, 32'h0, 26'h0);
    @(negedge clk);
    chk("pre_abort_req", {31'h0, imem_req_valid}, 32'h1);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("abort_instr", instr, 32'h0);
    chk("abort_pc", pc, 32'h0);
    chk("abort_retired", retired, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    chk("stale_ignored", instr, 32'h0);
    chk("restart_req", {31'h0, imem_req_valid}, 32'h1);
    model_restart();
    fetch(0, 0, 32'h4000_0001, 1'b0); exec(1'b1, 2'b00, 32'h0, 26'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
